ysyx_24080006_axi_sram: RTL and testbench

- AXI4-Lite slave responder: the memory-side end of the LSU/IFU bus protocol. It accepts single-beat read and write transactions and serves them from an internal word array.
- Response latency is programmable.
- Used in non-SOC simulation as the data/instruction memory behind the core's bus arbiter.
- One transaction is outstanding at a time, so the master-side handshake rules are exercised deterministically.

---
 rtl/ysyx_24080006_axi_sram.sv | 160 ++++++++++++++++
 tb/tb_ysyx_24080006_axi_sram.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_axi_sram.sv
// rtl/ysyx_24080006_axi_sram.sv - AXI4-Lite single-outstanding SRAM responder with programmable latency
// Optional: define YSYX_24080006_SRAM_RAND_DELAY_EN for LFSR-driven latency and ready gating.
module ysyx_24080006_axi_sram #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          READ_LAT   = 2,
    parameter int          WRITE_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam logic [DEPTH_LOG2-1:0] BASE_WORD = BASE_ADDR[DEPTH_LOG2+1:2];
    localparam logic [32:0]           END_ADDR  = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);

    typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP} state_t;

    state_t                state, state_next;
    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  err_q;
    logic                  ready_en;
    logic                  gate;
    logic                  wr_accept, rd_accept;
    logic [3:0]            lat_r, lat_w;

    wire ar_in_range = (araddr >= BASE_ADDR) && ({1'b0, araddr} < END_ADDR);
    wire aw_in_range = (awaddr >= BASE_ADDR) && ({1'b0, awaddr} < END_ADDR);
    wire [DEPTH_LOG2-1:0] ar_idx = araddr[DEPTH_LOG2+1:2] - BASE_WORD;
    wire [DEPTH_LOG2-1:0] aw_idx = awaddr[DEPTH_LOG2+1:2] - BASE_WORD;

`ifdef YSYX_24080006_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr <= 16'hACE1;
        else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign gate  = lfsr[4];
    assign lat_r = lfsr[3:0];
    assign lat_w = lfsr[3:0];
`else
    assign gate  = 1'b1;
    assign lat_r = 4'(READ_LAT);
    assign lat_w = 4'(WRITE_LAT);
`endif

    // Holds all readies low until the first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;
        case (state)
            IDLE: begin
                // A write wins the cycle; arready drops so the read stays pending.
                if (ready_en && gate && awvalid && wvalid) begin
                    awready    = 1'b1;
                    wready     = 1'b1;
                    wr_accept  = 1'b1;
                    state_next = W_WAIT;
                end else if (ready_en && gate) begin
                    arready = 1'b1;
                    if (arvalid) begin
                        rd_accept  = 1'b1;
                        state_next = R_WAIT;
                    end
                end
            end
            R_WAIT:  if (cnt == 4'd0) state_next = R_RESP;
            R_RESP:  if (rready)      state_next = IDLE;
            W_WAIT:  if (cnt == 4'd0) state_next = W_RESP;
            W_RESP:  if (bready)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 4'd0;
            idx_q  <= '0;
            err_q  <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= 32'h0;
            rresp  <= 2'b00;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_accept) begin
                        cnt   <= lat_w;
                        err_q <= !aw_in_range;
                    end else if (rd_accept) begin
                        cnt   <= lat_r;
                        err_q <= !ar_in_range;
                        idx_q <= ar_idx;
                    end
                end
                R_WAIT: begin
                    if (cnt == 4'd0) begin
                        rvalid <= 1'b1;
                        rdata  <= err_q ? 32'h0 : mem[idx_q];
                        rresp  <= err_q ? 2'b10 : 2'b00;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                R_RESP: if (rready) rvalid <= 1'b0;
                W_WAIT: begin
                    if (cnt == 4'd0) begin
                        bvalid <= 1'b1;
                        bresp  <= err_q ? 2'b10 : 2'b00;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                W_RESP: if (bready) bvalid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Memory is not reset; writes commit at the AW/W handshake edge.
    always_ff @(posedge clock) begin
        if (wr_accept && aw_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[aw_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
// tb/tb_ysyx_24080006_axi_sram.sv - directed self-checking bench for the AXI4-Lite SRAM responder
module tb_ysyx_24080006_axi_sram;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_24080006_axi_sram dut (
        .clock(clock), .reset_n(reset_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All driving and sampling happens 1-2 time units after the rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(posedge clock); #2; n++; end
        if (n >= 50) check("aw_timeout", 1, 0);
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clock); #1; n++; end
        if (n >= 50) check("b_timeout", 1, 0);
        resp = bresp;
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin @(posedge clock); #2; n++; end
        if (n >= 50) check("ar_timeout", 1, 0);
        @(posedge clock); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin @(posedge clock); #1; lat++; end
        if (lat >= 50) check("r_timeout", 1, 0);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("hold_rvalid", {31'h0, rvalid}, 32'h1);
            check("hold_rdata", rdata, data);
        end
        rready = 1'b1;
        @(posedge clock); #1;
        rready = 1'b0;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;

    initial begin
        reset_n = 1'b0; araddr = '0; arvalid = 0; rready = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        #12;
        check("rst_arready", {31'h0, arready}, 0);
        check("rst_awready", {31'h0, awready}, 0);
        check("rst_rvalid", {31'h0, rvalid}, 0);
        check("rst_bvalid", {31'h0, bvalid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {28'h0, rresp, bresp}, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_arready", {31'h0, arready}, 1);

        // Basic write/read and latency
        axi_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, r);
        check("basic_bresp", {30'h0, r}, 0);
        axi_read(32'h8000_0010, 0, d, r, lat);
        check("basic_rdata", d, 32'hDEADBEEF);
        check("basic_rresp", {30'h0, r}, 0);
        check("basic_lat", lat, 3);
        axi_read(32'h8000_0013, 0, d, r, lat);
        check("unaligned_rdata", d, 32'hDEADBEEF);

        // Byte strobes
        axi_write(32'h8000_0040, 32'h1122_3344, 4'hF, r);
        axi_write(32'h8000_0040, 32'h0000_AA00, 4'b0010, r);
        axi_read(32'h8000_0040, 0, d, r, lat);
        check("strb_0010", d, 32'h1122_AA44);
        axi_write(32'h8000_0040, 32'h5566_0000, 4'b1100, r);
        axi_read(32'h8000_0040, 0, d, r, lat);
        check("strb_1100", d, 32'h5566_AA44);
        axi_write(32'h8000_0040, 32'hFFFF_FFFF, 4'b0000, r);
        check("strb_0_bresp", {30'h0, r}, 0);
        axi_read(32'h8000_0040, 0, d, r, lat);
        check("strb_0_data", d, 32'h5566_AA44);

        // Backpressure: 5 held cycles, then arready the cycle after handshake
        axi_read(32'h8000_0010, 5, d, r, lat);
        check("bp_rdata", d, 32'hDEADBEEF);
        check("bp_rvalid_drop", {31'h0, rvalid}, 0);
        check("bp_arready", {31'h0, arready}, 1);

        // Simultaneous read and write to the same word: write first
        axi_write(32'h8000_0020, 32'h0, 4'hF, r);
        araddr = 32'h8000_0020; arvalid = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("sim_awready", {31'h0, awready}, 1);
        check("sim_arready", {31'h0, arready}, 0);
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin
            check("sim_no_rvalid", {31'h0, rvalid}, 0);
            @(posedge clock); #1; n++;
        end
        if (n >= 50) check("sim_b_timeout", 1, 0);
        bready = 1'b1;
        @(posedge clock); #1 bready = 1'b0;
        axi_read(32'h8000_0020, 0, d, r, lat);
        check("sim_rdata", d, 32'h12345678);

        // Out-of-range accesses
        axi_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, r);
        axi_read(32'h8001_0000, 0, d, r, lat);
        check("oor_rresp", {30'h0, r}, 32'h2);
        check("oor_rdata", d, 0);
        axi_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, r);
        check("oor_bresp", {30'h0, r}, 32'h2);
        axi_read(32'h8000_0000, 0, d, r, lat);
        check("oor_idx0", d, 32'hCAFE_F00D);
        check("last_word_rresp", {30'h0, r}, 0);
        axi_read(32'h8000_3FFC, 0, d, r, lat);
        check("last_word_inrange", {30'h0, r}, 0);

        // Reset during R_WAIT
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(posedge clock); #1 arvalid = 1'b0;
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'h0, rvalid}, 0);
        check("mid_rst_arready", {31'h0, arready}, 0);
        @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_arready", {31'h0, arready}, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("post_rst_no_rvalid", {31'h0, rvalid}, 0);
        end
        axi_read(32'h8000_0010, 0, d, r, lat);
        check("post_rst_mem_kept", d, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
